// File: rtl/mem_latch_ctrl_if.sv
// rtl/mem_latch_ctrl_if.sv - EX/MEM sequencing controller bus: cache completions, latch controls, dcache requests
interface mem_latch_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             em_valid;
  logic             em_dREN;
  logic             em_dWEN;
  logic             em_bEQ;
  logic             em_bNE;
  logic             em_flagZero;
  logic             em_halt;
  logic             dmem_ren;
  logic             dmem_wen;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             pc_br_sel;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  // master: the controller; slave: the pipeline/caches around it
  modport master (
    input  ihit, dhit, em_valid, em_dREN, em_dWEN, em_bEQ, em_bNE, em_flagZero, em_halt,
    output dmem_ren, dmem_wen, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_br_sel, halted, stall_cnt
  );

  modport slave (
    output ihit, dhit, em_valid, em_dREN, em_dWEN, em_bEQ, em_bNE, em_flagZero, em_halt,
    input  dmem_ren, dmem_wen, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_br_sel, halted, stall_cnt
  );
endinterface

// File: rtl/mem_latch_ctrl.sv
// rtl/mem_latch_ctrl.sv - EX/MEM stage sequencer: dcache requests, latch enables/flushes, branch resolve, halt
module mem_latch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic          CLK,
  input  logic          RST,
  mem_latch_ctrl_if.master bus
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] WAIT_D = 2'd1;
  localparam logic [1:0] WAIT_I = 2'd2;
  localparam logic [1:0] HALT   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic [CNT_W-1:0] stallCnt;

  logic memOp;
  logic iOk;
  logic dOk;
  logic adv;
  logic take;
  logic haltNow;
  logic reqGate;

  assign memOp   = bus.em_valid & (bus.em_dREN | bus.em_dWEN);
  // Each wait state remembers which side already completed, so that side is treated as done.
  assign iOk     = bus.ihit | (state == WAIT_D);
  assign dOk     = ~memOp | bus.dhit | (state == WAIT_I);
  assign adv     = iOk & dOk & (state != HALT);
  assign take    = bus.em_valid & ((bus.em_bEQ & bus.em_flagZero) | (bus.em_bNE & ~bus.em_flagZero));
  assign haltNow = bus.em_valid & bus.em_halt;
  assign reqGate = (state != WAIT_I) & (state != HALT);

  always_comb begin
    bus.dmem_ren     = 1'b0;
    bus.dmem_wen     = 1'b0;
    bus.pc_en        = 1'b0;
    bus.if_id_en     = 1'b0;
    bus.id_ex_en     = 1'b0;
    bus.ex_mem_en    = 1'b0;
    bus.mem_wb_en    = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.pc_br_sel    = 1'b0;
    if (!RST) begin
      // Store wins when both read and write are flagged.
      bus.dmem_wen = memOp & bus.em_dWEN & reqGate;
      bus.dmem_ren = memOp & bus.em_dREN & ~bus.em_dWEN & reqGate;
      if (adv) begin
        bus.pc_en     = ~haltNow;
        bus.if_id_en  = 1'b1;
        bus.id_ex_en  = 1'b1;
        bus.ex_mem_en = 1'b1;
        bus.mem_wb_en = 1'b1;
        if (take && !haltNow) begin
          bus.pc_br_sel    = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.id_ex_flush  = 1'b1;
          bus.ex_mem_flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    if (state == HALT) begin
      stateNext = HALT;
    end else if (adv) begin
      stateNext = haltNow ? HALT : RUN;
    end else if (iOk && !dOk) begin
      stateNext = WAIT_D;
    end else if (dOk && !iOk) begin
      stateNext = WAIT_I;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      stallCnt <= '0;
    end else begin
      state <= stateNext;
      if (!adv && state != HALT && stallCnt != {CNT_W{1'b1}}) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

  assign bus.halted    = (state == HALT);
  assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_mem_latch_ctrl.sv
// tb/tb_mem_latch_ctrl.sv - directed bench for mem_latch_ctrl (32-bit and 4-bit counter instances)
module tb_mem_latch_ctrl;

  logic CLK;
  logic RST;
  logic ihit, dhit, emValid, emDRen, emDWen, emBEq, emBNe, emFlagZero, emHalt;

  int checks;
  int failures;

  mem_latch_ctrl_if #(.CNT_W(32)) busA ();
  mem_latch_ctrl_if #(.CNT_W(4))  busB ();

  assign busA.ihit = ihit;        assign busB.ihit = ihit;
  assign busA.dhit = dhit;        assign busB.dhit = dhit;
  assign busA.em_valid = emValid; assign busB.em_valid = emValid;
  assign busA.em_dREN = emDRen;   assign busB.em_dREN = emDRen;
  assign busA.em_dWEN = emDWen;   assign busB.em_dWEN = emDWen;
  assign busA.em_bEQ = emBEq;     assign busB.em_bEQ = emBEq;
  assign busA.em_bNE = emBNe;     assign busB.em_bNE = emBNe;
  assign busA.em_flagZero = emFlagZero; assign busB.em_flagZero = emFlagZero;
  assign busA.em_halt = emHalt;   assign busB.em_halt = emHalt;

  mem_latch_ctrl #(.CNT_W(32)) dutA (.CLK(CLK), .RST(RST), .bus(busA.master));
  mem_latch_ctrl #(.CNT_W(4))  dutB (.CLK(CLK), .RST(RST), .bus(busB.master));

  // {ren, wen, pc, ifid, idex, exmem, memwb, ifidF, idexF, exmemF, brSel}
  logic [10:0] outs;
  assign outs = {busA.dmem_ren, busA.dmem_wen, busA.pc_en, busA.if_id_en, busA.id_ex_en,
                 busA.ex_mem_en, busA.mem_wb_en, busA.if_id_flush, busA.id_ex_flush,
                 busA.ex_mem_flush, busA.pc_br_sel};

  localparam logic [10:0] O_IDLE   = 11'b00_00000_000_0;
  localparam logic [10:0] O_ADV    = 11'b00_11111_000_0;
  localparam logic [10:0] O_RD     = 11'b10_00000_000_0;
  localparam logic [10:0] O_RD_ADV = 11'b10_11111_000_0;
  localparam logic [10:0] O_WR     = 11'b01_00000_000_0;
  localparam logic [10:0] O_TAKEN  = 11'b00_11111_111_1;
  localparam logic [10:0] O_HALT   = 11'b00_01111_000_0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setIn(input logic v, input logic r, input logic w, input logic beq, input logic bne,
                       input logic fz, input logic h, input logic ih, input logic dh);
    emValid = v; emDRen = r; emDWen = w; emBEq = beq; emBNe = bne;
    emFlagZero = fz; emHalt = h; ihit = ih; dhit = dh;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    RST = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // Reset forces outputs low even with a load and both hits present
    RST = 1'b1;
    setIn(1, 1, 0, 1, 0, 1, 0, 1, 1);
    chk("rst_outs", 32'(outs), 32'(O_IDLE));
    tick();
    chk("rst_cnt", busA.stall_cnt, 0);
    chk("rst_halted", 32'(busA.halted), 0);
    RST = 1'b0;

    // ALU-only stream
    for (int i = 0; i < 3; i++) begin
      setIn(1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("alu_outs%0d", i), 32'(outs), 32'(O_ADV));
      tick();
    end
    chk("alu_cnt", busA.stall_cnt, 0);

    // Load: dhit on cycle 3; ihit low in cycles 2-3 is ignored while in WAIT_D
    doReset();
    setIn(1, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("ld_c1", 32'(outs), 32'(O_RD));
    tick();
    setIn(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("ld_c2", 32'(outs), 32'(O_RD));
    tick();
    setIn(1, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("ld_c3", 32'(outs), 32'(O_RD_ADV));
    tick();
    chk("ld_cnt", busA.stall_cnt, 2);

    // Store: dhit on cycle 1, ihit on cycle 4; request not reissued in WAIT_I
    doReset();
    setIn(1, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("st_c1", 32'(outs), 32'(O_WR));
    tick();
    setIn(1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("st_c2", 32'(outs), 32'(O_IDLE));
    tick();
    setIn(1, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("st_c3", 32'(outs), 32'(O_IDLE));
    tick();
    setIn(1, 0, 1, 0, 0, 0, 0, 1, 0);
    chk("st_c4", 32'(outs), 32'(O_ADV));
    tick();
    chk("st_cnt", busA.stall_cnt, 3);

    // Read+write together is a write
    setIn(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("rw_is_wr", 32'(outs), 32'(O_WR));
    doReset();

    // Branch resolution
    setIn(1, 0, 0, 1, 0, 1, 0, 1, 0);
    chk("beq_taken", 32'(outs), 32'(O_TAKEN));
    tick();
    setIn(1, 0, 0, 0, 1, 1, 0, 1, 0);
    chk("bne_not", 32'(outs), 32'(O_ADV));
    tick();
    setIn(1, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("bne_taken", 32'(outs), 32'(O_TAKEN));
    tick();
    setIn(0, 0, 0, 1, 0, 1, 0, 1, 0);
    chk("bubble_beq", 32'(outs), 32'(O_ADV));
    tick();
    setIn(0, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("bubble_ld", 32'(outs), 32'(O_ADV));
    tick();
    chk("br_cnt", busA.stall_cnt, 0);

    // One fetch stall, then HALT (with a taken BEQ that must be suppressed)
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_halt_stall", 32'(outs), 32'(O_IDLE));
    tick();
    setIn(1, 0, 0, 1, 0, 1, 1, 1, 0);
    chk("halt_adv", 32'(outs), 32'(O_HALT));
    tick();
    for (int i = 0; i < 10; i++) begin
      setIn(1, 1, 0, 0, 0, 0, 0, 1, 1);
      chk($sformatf("halt_outs%0d", i), 32'(outs), 32'(O_IDLE));
      chk($sformatf("halt_flag%0d", i), 32'(busA.halted), 1);
      tick();
    end
    chk("halt_cnt_frozen", busA.stall_cnt, 1);
    doReset();
    chk("halt_rst_flag", 32'(busA.halted), 0);
    chk("halt_rst_cnt", busA.stall_cnt, 0);

    // 20 stalls: 32-bit counter reaches 20, 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      setIn(1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("sat_cnt32", busA.stall_cnt, 20);
    chk("sat_cnt4", 32'(busB.stall_cnt), 15);

    // Reset during WAIT_D drops the request at once; state is RUN afterwards
    doReset();
    setIn(1, 1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    setIn(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_req", 32'(outs), 32'(O_RD));
    RST = 1'b1;
    #1;
    chk("wd_rst_drop", 32'(busA.dmem_ren), 0);
    tick();
    RST = 1'b0;
    setIn(1, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("wd_rst_run", 32'(outs), 32'(O_RD));
    chk("wd_rst_cnt", busA.stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
